// File: rtl/alu_reservation_station.sv
// Reservation station for integer ALU operations: holds dispatched ops until
// both operands are present (directly or via CDB snoop), then issues one per cycle.
//
// state   | meaning
// FREE    | entry empty, available for dispatch
// WAITING | op held, at least one operand still awaiting the CDB
// READY   | both operands captured, eligible for selection
module alu_reservation_station #(
  parameter int WIDTH   = 31,
  parameter int A_WIDTH = 3,
  parameter int ROB     = 2,
  parameter int ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 globalReset,
  input  logic                 clear,
  input  logic                 dispatchValid,
  input  logic [A_WIDTH:0]     dispatchControl,
  input  logic [ROB:0]         dispatchRob,
  input  logic [WIDTH:0]       dispatchSrc1,
  input  logic [WIDTH:0]       dispatchSrc2,
  input  logic                 dispatchRdy1,
  input  logic                 dispatchRdy2,
  input  logic [ROB:0]         dispatchTag1,
  input  logic [ROB:0]         dispatchTag2,
  input  logic                 cdbValid,
  input  logic [ROB:0]         cdbRob,
  input  logic [WIDTH:0]       cdbResult,
  input  logic                 aluAvailable,
  output logic                 stationFull,
  output logic                 issueValid,
  output logic signed [WIDTH:0] src1,
  output logic signed [WIDTH:0] src2,
  output logic [A_WIDTH:0]     ALUControl,
  output logic [ROB:0]         ALURob
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WAITING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t           st_q   [ENTRIES];
  state_t           st_d   [ENTRIES];
  logic [A_WIDTH:0] ctrl_q [ENTRIES];
  logic [A_WIDTH:0] ctrl_d [ENTRIES];
  logic [ROB:0]     rob_q  [ENTRIES];
  logic [ROB:0]     rob_d  [ENTRIES];
  logic [WIDTH:0]   val1_q [ENTRIES];
  logic [WIDTH:0]   val1_d [ENTRIES];
  logic [WIDTH:0]   val2_q [ENTRIES];
  logic [WIDTH:0]   val2_d [ENTRIES];
  logic [ROB:0]     tag1_q [ENTRIES];
  logic [ROB:0]     tag1_d [ENTRIES];
  logic [ROB:0]     tag2_q [ENTRIES];
  logic [ROB:0]     tag2_d [ENTRIES];
  logic             rdy1_q [ENTRIES];
  logic             rdy1_d [ENTRIES];
  logic             rdy2_q [ENTRIES];
  logic             rdy2_d [ENTRIES];

  logic          full;
  logic          alloc_found;
  logic [IW-1:0] alloc_idx;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          disp_fire;
  logic          issue_fire;
  logic          byp1;
  logic          byp2;

  // Occupancy, lowest-free allocation and lowest-ready selection
  always_comb begin
    full        = 1'b1;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (st_q[i] == FREE) begin
        full = 1'b0;
        if (!alloc_found) begin
          alloc_found = 1'b1;
          alloc_idx   = i[IW-1:0];
        end
      end
      if (st_q[i] == READY && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = i[IW-1:0];
      end
    end
  end

  assign stationFull = full;
  assign disp_fire   = dispatchValid && !full && alloc_found;
  assign issue_fire  = aluAvailable && sel_found;
  assign byp1        = !dispatchRdy1 && cdbValid && (dispatchTag1 == cdbRob);
  assign byp2        = !dispatchRdy2 && cdbValid && (dispatchTag2 == cdbRob);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      st_d[i]   = st_q[i];
      ctrl_d[i] = ctrl_q[i];
      rob_d[i]  = rob_q[i];
      val1_d[i] = val1_q[i];
      val2_d[i] = val2_q[i];
      tag1_d[i] = tag1_q[i];
      tag2_d[i] = tag2_q[i];
      rdy1_d[i] = rdy1_q[i];
      rdy2_d[i] = rdy2_q[i];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (st_q[i] == WAITING) begin
        if (cdbValid && !rdy1_q[i] && (tag1_q[i] == cdbRob)) begin
          val1_d[i] = cdbResult;
          rdy1_d[i] = 1'b1;
        end
        if (cdbValid && !rdy2_q[i] && (tag2_q[i] == cdbRob)) begin
          val2_d[i] = cdbResult;
          rdy2_d[i] = 1'b1;
        end
        if (rdy1_d[i] && rdy2_d[i]) begin
          st_d[i] = READY;
        end
      end
      if (issue_fire && (sel_idx == i[IW-1:0])) begin
        st_d[i] = FREE;
      end
      // Allocation only targets FREE entries, so it never collides with issue
      if (disp_fire && (alloc_idx == i[IW-1:0])) begin
        ctrl_d[i] = dispatchControl;
        rob_d[i]  = dispatchRob;
        tag1_d[i] = dispatchTag1;
        tag2_d[i] = dispatchTag2;
        val1_d[i] = byp1 ? cdbResult : dispatchSrc1;
        val2_d[i] = byp2 ? cdbResult : dispatchSrc2;
        rdy1_d[i] = dispatchRdy1 || byp1;
        rdy2_d[i] = dispatchRdy2 || byp2;
        st_d[i]   = ((dispatchRdy1 || byp1) && (dispatchRdy2 || byp2)) ? READY : WAITING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (globalReset || clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        st_q[i] <= FREE;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        st_q[i] <= st_d[i];
      end
    end
  end

  // Payload is only meaningful while the entry is occupied, so it needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      ctrl_q[i] <= ctrl_d[i];
      rob_q[i]  <= rob_d[i];
      val1_q[i] <= val1_d[i];
      val2_q[i] <= val2_d[i];
      tag1_q[i] <= tag1_d[i];
      tag2_q[i] <= tag2_d[i];
      rdy1_q[i] <= rdy1_d[i];
      rdy2_q[i] <= rdy2_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (globalReset || clear) begin
      issueValid <= 1'b0;
      src1       <= '0;
      src2       <= '0;
      ALUControl <= '0;
      ALURob     <= '0;
    end else begin
      issueValid <= issue_fire;
      if (issue_fire) begin
        src1       <= val1_q[sel_idx];
        src2       <= val2_q[sel_idx];
        ALUControl <= ctrl_q[sel_idx];
        ALURob     <= rob_q[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: hand-computed expectations checked
// with immediate assertions one cycle step at a time.
module tb_alu_reservation_station;

  logic        clk;
  logic        globalReset;
  logic        clear;
  logic        dispatchValid;
  logic [3:0]  dispatchControl;
  logic [2:0]  dispatchRob;
  logic [31:0] dispatchSrc1;
  logic [31:0] dispatchSrc2;
  logic        dispatchRdy1;
  logic        dispatchRdy2;
  logic [2:0]  dispatchTag1;
  logic [2:0]  dispatchTag2;
  logic        cdbValid;
  logic [2:0]  cdbRob;
  logic [31:0] cdbResult;
  logic        aluAvailable;
  logic        stationFull;
  logic        issueValid;
  logic signed [31:0] src1;
  logic signed [31:0] src2;
  logic [3:0]  ALUControl;
  logic [2:0]  ALURob;

  int vectors;
  int miscompares;

  alu_reservation_station dut (
    .clk(clk), .globalReset(globalReset), .clear(clear),
    .dispatchValid(dispatchValid), .dispatchControl(dispatchControl),
    .dispatchRob(dispatchRob), .dispatchSrc1(dispatchSrc1), .dispatchSrc2(dispatchSrc2),
    .dispatchRdy1(dispatchRdy1), .dispatchRdy2(dispatchRdy2),
    .dispatchTag1(dispatchTag1), .dispatchTag2(dispatchTag2),
    .cdbValid(cdbValid), .cdbRob(cdbRob), .cdbResult(cdbResult),
    .aluAvailable(aluAvailable), .stationFull(stationFull), .issueValid(issueValid),
    .src1(src1), .src2(src2), .ALUControl(ALUControl), .ALURob(ALURob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [3:0] c, input logic [2:0] r,
                      input logic [31:0] s1, input logic r1, input logic [2:0] t1,
                      input logic [31:0] s2, input logic r2, input logic [2:0] t2);
    dispatchValid   = 1'b1;
    dispatchControl = c;
    dispatchRob     = r;
    dispatchSrc1    = s1;
    dispatchRdy1    = r1;
    dispatchTag1    = t1;
    dispatchSrc2    = s2;
    dispatchRdy2    = r2;
    dispatchTag2    = t2;
  endtask

  task automatic cdb(input logic v, input logic [2:0] r, input logic [31:0] d);
    cdbValid  = v;
    cdbRob    = r;
    cdbResult = d;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    globalReset = 1'b1;
    clear = 1'b0;
    dispatchValid = 1'b0;
    dispatchControl = '0;
    dispatchRob = '0;
    dispatchSrc1 = '0;
    dispatchSrc2 = '0;
    dispatchRdy1 = 1'b0;
    dispatchRdy2 = 1'b0;
    dispatchTag1 = '0;
    dispatchTag2 = '0;
    cdbValid = 1'b0;
    cdbRob = '0;
    cdbResult = '0;
    aluAvailable = 1'b0;
    tick();
    tick();
    globalReset = 1'b0;
    chk("rst_valid", {31'd0, issueValid}, 32'd0);
    chk("rst_src1", src1, 32'd0);
    chk("rst_src2", src2, 32'd0);
    chk("rst_ctrl", {28'd0, ALUControl}, 32'd0);
    chk("rst_rob", {29'd0, ALURob}, 32'd0);
    chk("rst_full", {31'd0, stationFull}, 32'd0);

    // Both operands ready: issue two edges after dispatch
    aluAvailable = 1'b1;
    disp(4'h2, 3'd3, 32'd5, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0);
    tick();
    dispatchValid = 1'b0;
    chk("t1_nolat", {31'd0, issueValid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, issueValid}, 32'd1);
    chk("t1_src1", src1, 32'd5);
    chk("t1_src2", src2, 32'd7);
    chk("t1_rob", {29'd0, ALURob}, 32'd3);
    chk("t1_ctrl", {28'd0, ALUControl}, 32'd2);
    tick();
    chk("t1_pulse", {31'd0, issueValid}, 32'd0);
    chk("t1_hold", src1, 32'd5);
    chk("t1_empty", {31'd0, stationFull}, 32'd0);

    // src2 waits on tag 1, woken by CDB two cycles after dispatch
    disp(4'h3, 3'd2, 32'd10, 1'b1, 3'd0, 32'd0, 1'b0, 3'd1);
    tick();
    dispatchValid = 1'b0;
    tick();
    chk("t2_wait", {31'd0, issueValid}, 32'd0);
    cdb(1'b1, 3'd1, 32'hFFFF_FFFC);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    chk("t2_wake_lat", {31'd0, issueValid}, 32'd0);
    tick();
    chk("t2_valid", {31'd0, issueValid}, 32'd1);
    chk("t2_src2", src2, 32'hFFFF_FFFC);
    chk("t2_src1", src1, 32'd10);
    chk("t2_rob", {29'd0, ALURob}, 32'd2);

    // Dispatch bypass from the CDB in the same cycle
    disp(4'h5, 3'd1, 32'd0, 1'b0, 3'd2, 32'd1, 1'b1, 3'd0);
    cdb(1'b1, 3'd2, 32'd9);
    tick();
    dispatchValid = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    chk("t3_lat", {31'd0, issueValid}, 32'd0);
    tick();
    chk("t3_valid", {31'd0, issueValid}, 32'd1);
    chk("t3_src1", src1, 32'd9);
    chk("t3_src2", src2, 32'd1);
    chk("t3_rob", {29'd0, ALURob}, 32'd1);
    tick();

    // Fill all four entries with waiting ops; entries 0,2 wait on tag 6, 1,3 on tag 7
    for (int k = 0; k < 4; k++) begin
      disp(k[3:0], k[2:0], 32'd0, 1'b0, (k % 2 == 0) ? 3'd6 : 3'd7,
           32'd100 + k, 1'b1, 3'd0);
      tick();
    end
    chk("t4_full", {31'd0, stationFull}, 32'd1);
    disp(4'h9, 3'd4, 32'd55, 1'b1, 3'd0, 32'd56, 1'b1, 3'd0);
    tick();
    dispatchValid = 1'b0;
    chk("t4_drop_full", {31'd0, stationFull}, 32'd1);
    chk("t4_drop_noissue", {31'd0, issueValid}, 32'd0);
    cdb(1'b1, 3'd6, 32'd60);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    chk("t4_wake_lat", {31'd0, issueValid}, 32'd0);
    tick();
    chk("t4_e0_valid", {31'd0, issueValid}, 32'd1);
    chk("t4_e0_rob", {29'd0, ALURob}, 32'd0);
    chk("t4_e0_src1", src1, 32'd60);
    chk("t4_e0_src2", src2, 32'd100);
    chk("t4_notfull", {31'd0, stationFull}, 32'd0);
    tick();
    chk("t4_e2_valid", {31'd0, issueValid}, 32'd1);
    chk("t4_e2_rob", {29'd0, ALURob}, 32'd2);
    chk("t4_e2_src2", src2, 32'd102);
    tick();
    chk("t4_idle", {31'd0, issueValid}, 32'd0);

    // Three ready entries held while the ALU is busy
    aluAvailable = 1'b0;
    disp(4'h7, 3'd5, 32'd1, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0);
    cdb(1'b1, 3'd7, 32'd70);
    tick();
    dispatchValid = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    tick();
    chk("t5_hold_a", {31'd0, issueValid}, 32'd0);
    tick();
    chk("t5_hold_b", {31'd0, issueValid}, 32'd0);
    chk("t5_full", {31'd0, stationFull}, 32'd0);
    aluAvailable = 1'b1;
    tick();
    chk("t5_i0_valid", {31'd0, issueValid}, 32'd1);
    chk("t5_i0_rob", {29'd0, ALURob}, 32'd5);
    chk("t5_i0_src1", src1, 32'd1);
    tick();
    chk("t5_i1_valid", {31'd0, issueValid}, 32'd1);
    chk("t5_i1_rob", {29'd0, ALURob}, 32'd1);
    chk("t5_i1_src1", src1, 32'd70);
    chk("t5_i1_src2", src2, 32'd101);
    tick();
    chk("t5_i2_valid", {31'd0, issueValid}, 32'd1);
    chk("t5_i2_rob", {29'd0, ALURob}, 32'd3);
    chk("t5_i2_src2", src2, 32'd103);
    tick();
    chk("t5_done", {31'd0, issueValid}, 32'd0);
    chk("t5_empty", {31'd0, stationFull}, 32'd0);

    // Flush alongside a dispatch and a pending issue
    aluAvailable = 1'b0;
    disp(4'h1, 3'd6, 32'd11, 1'b1, 3'd0, 32'd12, 1'b1, 3'd0);
    tick();
    aluAvailable = 1'b1;
    clear = 1'b1;
    disp(4'h2, 3'd7, 32'd13, 1'b1, 3'd0, 32'd14, 1'b1, 3'd0);
    tick();
    clear = 1'b0;
    dispatchValid = 1'b0;
    chk("t6_valid", {31'd0, issueValid}, 32'd0);
    chk("t6_full", {31'd0, stationFull}, 32'd0);
    chk("t6_rob", {29'd0, ALURob}, 32'd0);
    chk("t6_src1", src1, 32'd0);
    tick();
    chk("t6_stale_a", {31'd0, issueValid}, 32'd0);
    tick();
    chk("t6_stale_b", {31'd0, issueValid}, 32'd0);
    chk("t6_stale_rob", {29'd0, ALURob}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
